// File: rtl/ldpc_msg_pkg.sv
// Shared LDPC message definitions: default widths, expander FSM encoding and
// the compressed check-node record exchanged between min-sum unit, store and expander.
package ldpc_msg_pkg;

   localparam int unsigned MAX_DEG = 20;
   localparam int unsigned MAG_W   = 4;
   localparam int unsigned IDX_W   = 5;
   localparam int unsigned OFFSET  = 1;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_STREAM = 1'b1;

   typedef struct packed {
      logic [MAG_W-1:0]   min1;
      logic [MAG_W-1:0]   min2;
      logic [IDX_W-1:0]   idx;
      logic [MAX_DEG-1:0] signs;
      logic [IDX_W-1:0]   deg;
   } cn_rec_t;

endpackage

// File: rtl/cn_sign_parity.sv
// Combinational sign parity of a check-node record: XOR of the sign bits of the
// active edges only; bits at or above the effective degree do not contribute.
module cn_sign_parity
   import ldpc_msg_pkg::*;
#(
   parameter int unsigned N_SIGNS = MAX_DEG,
   parameter int unsigned CNT_W   = IDX_W
)(
   input  logic [N_SIGNS-1:0] i_signs,
   input  logic [CNT_W-1:0]   i_deg_eff,
   output logic               o_par
);

   always_comb begin
      o_par = 1'b0;
      for (int e = 0; e < int'(N_SIGNS); e++) begin
         if (CNT_W'(e) < i_deg_eff) o_par = o_par ^ i_signs[e];
      end
   end

endmodule

// File: rtl/cn_msg_expander.sv
// Expands a compressed check-node record into per-edge offset-min-sum C2V
// messages, one edge per cycle, with valid/ready on both sides.
module cn_msg_expander
   import ldpc_msg_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [MAG_W-1:0]   in_min1,
   input  logic [MAG_W-1:0]   in_min2,
   input  logic [IDX_W-1:0]   in_min1_idx,
   input  logic [MAX_DEG-1:0] in_signs,
   input  logic [IDX_W-1:0]   in_deg,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_sign,
   output logic [MAG_W-1:0]   out_mag,
   output logic [IDX_W-1:0]   out_edge,
   output logic               out_last
);

   logic [0:0]         r_state;
   logic [MAG_W-1:0]   r_min1;
   logic [MAG_W-1:0]   r_min2;
   logic [IDX_W-1:0]   r_idx;
   logic [MAX_DEG-1:0] r_signs;
   logic [IDX_W-1:0]   r_deg_eff;
   logic               r_par;

   logic               w_fire;
   logic               w_accept;
   logic               w_beat_en;
   logic [IDX_W-1:0]   w_deg_eff_in;
   logic               w_par_in;

   logic [MAG_W-1:0]   w_src_min1;
   logic [MAG_W-1:0]   w_src_min2;
   logic [IDX_W-1:0]   w_src_idx;
   logic [MAX_DEG-1:0] w_src_signs;
   logic [IDX_W-1:0]   w_src_deg;
   logic               w_src_par;
   logic [IDX_W-1:0]   w_src_edge;
   logic [MAG_W-1:0]   w_raw;

   logic               w_beat_sign;
   logic [MAG_W-1:0]   w_beat_mag;
   logic               w_beat_last;

   logic [0:0]         w_state_nxt;
   logic               w_valid_nxt;
   logic               w_sign_nxt;
   logic [MAG_W-1:0]   w_mag_nxt;
   logic [IDX_W-1:0]   w_edge_nxt;
   logic               w_last_nxt;

   assign w_fire       = out_valid & out_ready;
   assign w_deg_eff_in = (in_deg > IDX_W'(MAX_DEG)) ? IDX_W'(MAX_DEG) : in_deg;
   // A new record is taken while idle, or on the handshake of the last beat.
   assign in_ready     = ~rst & ((r_state == ST_IDLE) | (w_fire & out_last));
   assign w_accept     = in_valid & in_ready;
   assign w_beat_en    = (w_accept & (w_deg_eff_in != '0)) | (w_fire & ~out_last);

   cn_sign_parity #(
      .N_SIGNS (MAX_DEG),
      .CNT_W   (IDX_W)
   ) u_sign_parity (
      .i_signs   (in_signs),
      .i_deg_eff (w_deg_eff_in),
      .o_par     (w_par_in)
   );

   // Next beat comes from the incoming record on accept, else from the stored one.
   always_comb begin
      w_src_min1  = w_accept ? in_min1      : r_min1;
      w_src_min2  = w_accept ? in_min2      : r_min2;
      w_src_idx   = w_accept ? in_min1_idx  : r_idx;
      w_src_signs = w_accept ? in_signs     : r_signs;
      w_src_deg   = w_accept ? w_deg_eff_in : r_deg_eff;
      w_src_par   = w_accept ? w_par_in     : r_par;
      w_src_edge  = w_accept ? '0 : out_edge + IDX_W'(1);
      w_raw       = (w_src_edge == w_src_idx) ? w_src_min2 : w_src_min1;
      w_beat_mag  = (w_raw > MAG_W'(OFFSET)) ? w_raw - MAG_W'(OFFSET) : '0;
      w_beat_sign = w_src_par ^ w_src_signs[w_src_edge];
      w_beat_last = (w_src_edge == w_src_deg - IDX_W'(1));
   end

   always_comb begin
      w_state_nxt = r_state;
      w_valid_nxt = out_valid;
      w_sign_nxt  = out_sign;
      w_mag_nxt   = out_mag;
      w_edge_nxt  = out_edge;
      w_last_nxt  = out_last;
      case (r_state)
         ST_IDLE:   w_state_nxt = ST_IDLE;
         ST_STREAM: begin
            if (w_fire && out_last) begin
               w_state_nxt = ST_IDLE;
               w_valid_nxt = 1'b0;
            end
         end
         default:   w_state_nxt = ST_IDLE;
      endcase
      if (w_beat_en) begin
         w_state_nxt = ST_STREAM;
         w_valid_nxt = 1'b1;
         w_sign_nxt  = w_beat_sign;
         w_mag_nxt   = w_beat_mag;
         w_edge_nxt  = w_src_edge;
         w_last_nxt  = w_beat_last;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         out_valid <= 1'b0;
         out_sign  <= 1'b0;
         out_mag   <= '0;
         out_edge  <= '0;
         out_last  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         out_valid <= w_valid_nxt;
         out_sign  <= w_sign_nxt;
         out_mag   <= w_mag_nxt;
         out_edge  <= w_edge_nxt;
         out_last  <= w_last_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_min1    <= '0;
         r_min2    <= '0;
         r_idx     <= '0;
         r_signs   <= '0;
         r_deg_eff <= '0;
         r_par     <= 1'b0;
      end else if (w_accept) begin
         r_min1    <= in_min1;
         r_min2    <= in_min2;
         r_idx     <= in_min1_idx;
         r_signs   <= in_signs;
         r_deg_eff <= w_deg_eff_in;
         r_par     <= w_par_in;
      end
   end

endmodule

// File: tb/tb_cn_msg_expander.sv
// Self-checking bench for cn_msg_expander: hand-computed record table, corner
// sequences, and random traffic against a per-record beat-list reference model.
module tb_cn_msg_expander;
   import ldpc_msg_pkg::*;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic               out_sign;
   logic [MAG_W-1:0]   out_mag;
   logic [IDX_W-1:0]   out_edge;
   logic               out_last;
   cn_rec_t            cur_rec = '0;

   cn_msg_expander dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_min1     (cur_rec.min1),
      .in_min2     (cur_rec.min2),
      .in_min1_idx (cur_rec.idx),
      .in_signs    (cur_rec.signs),
      .in_deg      (cur_rec.deg),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_sign    (out_sign),
      .out_mag     (out_mag),
      .out_edge    (out_edge),
      .out_last    (out_last)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic             sign;
      logic [MAG_W-1:0] mag;
      logic [IDX_W-1:0] edge_n;
      logic             last;
   } beat_t;

   typedef struct {
      cn_rec_t rec;
      int      n_beats;
      int      mag_sum;
      int      neg_cnt;
   } vec_t;

   beat_t exp_q[$];
   int    checks = 0;
   int    errors = 0;
   int    beat_cnt = 0;
   int    mag_sum = 0;
   int    neg_cnt = 0;
   int    ready_mode = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: list every beat the record must produce, straight from the rules.
   function automatic void model_push(input cn_rec_t r);
      int    d;
      int    ones;
      int    raw;
      int    s;
      beat_t b;
      d = (int'(r.deg) > int'(MAX_DEG)) ? int'(MAX_DEG) : int'(r.deg);
      ones = 0;
      for (int e = 0; e < d; e++) ones += r.signs[e] ? 1 : 0;
      for (int e = 0; e < d; e++) begin
         raw      = (e == int'(r.idx)) ? int'(r.min2) : int'(r.min1);
         s        = (ones + (r.signs[e] ? 1 : 0)) % 2;
         b.sign   = (s == 1);
         b.mag    = (raw > int'(OFFSET)) ? MAG_W'(raw - int'(OFFSET)) : '0;
         b.edge_n = IDX_W'(e);
         b.last   = (e == d - 1);
         exp_q.push_back(b);
      end
   endfunction

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         1:       out_ready = ~out_ready;
         2:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b1;
      endcase
   end

   // Monitor: sampled on the falling edge, i.e. what the next rising edge will see.
   beat_t prev_b;
   logic  prev_stall = 1'b0;
   always @(negedge clk) begin
      beat_t act;
      beat_t e;
      act = '{sign: out_sign, mag: out_mag, edge_n: out_edge, last: out_last};
      if (rst) begin
         exp_q.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) check("stall_hold", int'(act), int'(prev_b));
         check("valid_when_pending", int'(out_valid), (exp_q.size() > 0) ? 1 : 0);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_beat", exp_q.size(), 1);
            end else begin
               e = exp_q.pop_front();
               checks++;
               if (act != e) begin
                  errors++;
                  $display("FAIL beat: got sign=%0b mag=%0d edge=%0d last=%0b expected sign=%0b mag=%0d edge=%0d last=%0b",
                           act.sign, act.mag, act.edge_n, act.last, e.sign, e.mag, e.edge_n, e.last);
               end
               beat_cnt++;
               mag_sum += int'(out_mag);
               neg_cnt += out_sign ? 1 : 0;
            end
         end
         if (in_valid && in_ready) begin
            if (out_valid) check("accept_on_last_beat", int'(out_last & out_ready), 1);
            model_push(cur_rec);
         end
         prev_stall = out_valid & ~out_ready;
         prev_b     = act;
      end
   end

   task automatic send(input cn_rec_t r);
      int ok;
      ok = 0;
      @(posedge clk); #1;
      cur_rec  = r;
      in_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
      end
      check("send_accepted", ok, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int ok;
      ok = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!out_valid && exp_q.size() == 0) begin ok = 1; break; end
      end
      check("drain_done", ok, 1);
   endtask

   task automatic clr_counts();
      beat_cnt = 0; mag_sum = 0; neg_cnt = 0;
   endtask

   vec_t vecs[7];
   cn_rec_t r;
   int ok;

   initial begin
      vecs[0] = '{rec: '{min1: 4'd1,  min2: 4'd2,  idx: 5'd1,  signs: 20'h00000, deg: 5'd20}, n_beats: 20, mag_sum: 1,  neg_cnt: 0};
      vecs[1] = '{rec: '{min1: 4'd5,  min2: 4'd9,  idx: 5'd3,  signs: 20'h00005, deg: 5'd20}, n_beats: 20, mag_sum: 84, neg_cnt: 2};
      vecs[2] = '{rec: '{min1: 4'd4,  min2: 4'd9,  idx: 5'd7,  signs: 20'hFFFFF, deg: 5'd3},  n_beats: 3,  mag_sum: 9,  neg_cnt: 0};
      vecs[3] = '{rec: '{min1: 4'd6,  min2: 4'd7,  idx: 5'd0,  signs: 20'h0000F, deg: 5'd0},  n_beats: 0,  mag_sum: 0,  neg_cnt: 0};
      vecs[4] = '{rec: '{min1: 4'd0,  min2: 4'd15, idx: 5'd19, signs: 20'h00000, deg: 5'd25}, n_beats: 20, mag_sum: 14, neg_cnt: 0};
      vecs[5] = '{rec: '{min1: 4'd15, min2: 4'd15, idx: 5'd0,  signs: 20'h00001, deg: 5'd1},  n_beats: 1,  mag_sum: 14, neg_cnt: 0};
      vecs[6] = '{rec: '{min1: 4'd2,  min2: 4'd1,  idx: 5'd0,  signs: 20'h00002, deg: 5'd2},  n_beats: 2,  mag_sum: 1,  neg_cnt: 1};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_in_ready", int'(in_ready), 0);
      check("reset_out_fields", int'({out_sign, out_mag, out_edge, out_last}), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("idle_in_ready", int'(in_ready), 1);

      // Table of records with hand-computed aggregates, full throughput.
      for (int i = 0; i < 7; i++) begin
         clr_counts();
         send(vecs[i].rec);
         wait_idle();
         check($sformatf("vec%0d_beats", i), beat_cnt, vecs[i].n_beats);
         check($sformatf("vec%0d_mag_sum", i), mag_sum, vecs[i].mag_sum);
         check($sformatf("vec%0d_neg_cnt", i), neg_cnt, vecs[i].neg_cnt);
      end

      // Back-pressure with a second record waiting on the last-beat handshake.
      ready_mode = 1;
      clr_counts();
      send('{min1: 4'd3, min2: 4'd8, idx: 5'd2, signs: 20'h00013, deg: 5'd5});
      send('{min1: 4'd7, min2: 4'd2, idx: 5'd0, signs: 20'h00006, deg: 5'd4});
      wait_idle();
      check("bp_beats", beat_cnt, 9);
      ready_mode = 0;

      // Reset in the middle of a record.
      clr_counts();
      send('{min1: 4'd9, min2: 4'd12, idx: 5'd10, signs: 20'h12345, deg: 5'd20});
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         if (out_valid && out_edge == 5'd5) begin ok = 1; break; end
         @(negedge clk);
      end
      check("reached_edge5", ok, 1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midrst_out_valid", int'(out_valid), 0);
      check("midrst_out_fields", int'({out_sign, out_mag, out_edge, out_last}), 0);
      check("midrst_in_ready", int'(in_ready), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("postrst_in_ready", int'(in_ready), 1);
      clr_counts();
      send('{min1: 4'd2, min2: 4'd5, idx: 5'd4, signs: 20'h80001, deg: 5'd20});
      wait_idle();
      check("postrst_beats", beat_cnt, 20);

      // Random records under random back-pressure.
      ready_mode = 2;
      for (int i = 0; i < 300; i++) begin
         r.min1  = MAG_W'($urandom_range(0, 15));
         r.min2  = MAG_W'($urandom_range(0, 15));
         r.idx   = IDX_W'($urandom_range(0, 31));
         r.signs = MAX_DEG'($urandom());
         r.deg   = IDX_W'($urandom_range(0, 31));
         send(r);
      end
      wait_idle();
      ready_mode = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cn_msg_expander.md
Name: cn_msg_expander

Overview:
- Expands a compressed check-node record (min1, min2, min1 index, per-edge signs) into per-edge check-to-variable messages, one edge per cycle, with offset-min-sum correction.
- This is the decompression end of the min-sum unit.
- Sits between the check-node record store and the variable-node update datapath of the LDPC decoder.
- Valid/ready handshake on both sides.

Parameters:
- MAX_DEG, 20, maximum check-node degree (edges per record).
- MAG_W, 4, magnitude width in bits (unsigned).
- IDX_W, 5, edge index / degree width in bits; must satisfy 2**IDX_W > MAX_DEG.
- OFFSET, 1, offset subtracted from every output magnitude, saturating at 0.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  compressed record present.
- in_ready  output  1  block accepts a record this cycle.
- in_min1  input  MAG_W  smallest incoming magnitude.
- in_min2  input  MAG_W  second-smallest incoming magnitude.
- in_min1_idx  input  IDX_W  edge holding min1.
- in_signs  input  MAX_DEG  sign of each incoming V2C message; bit e is edge e, 1 = negative.
- in_deg  input  IDX_W  active degree of this record.
- out_valid  output  1  output beat present.
- out_ready  input  1  downstream accepts the beat.
- out_sign  output  1  C2V sign for out_edge.
- out_mag  output  MAG_W  C2V magnitude for out_edge.
- out_edge  output  IDX_W  edge number, 0..deg-1.
- out_last  output  1  final edge of the record.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset state: on rst=1 at a clock edge, all of the following are cleared:
  - FSM goes to IDLE.
  - out_valid=0, out_sign=0, out_mag=0, out_edge=0, out_last=0.
  - Edge counter = 0.
  - Record registers are cleared.
  - in_ready is 0 while rst=1.
- Mid-record reset: the current record is abandoned and no further beats are emitted.
- FSM states: IDLE and STREAM.
- in_ready:
  - 1 in IDLE.
  - 1 in STREAM only on a cycle where out_valid & out_ready & out_last (back-to-back records).
  - 0 otherwise.
- Accept (in_valid & in_ready):
  - Register min1, min2, idx and signs.
  - deg_eff = min(in_deg, MAX_DEG).
  - Sign parity P = XOR of in_signs[0..deg_eff-1]; bits at or above deg_eff are ignored.
  - If deg_eff=0: record is dropped, FSM stays in/returns to IDLE, no beats.
  - Otherwise: edge counter=0, FSM to STREAM, out_valid=1 on the next cycle (latency 1 cycle from accept to first beat).
- Beat contents for edge e:
  - out_sign = P ^ signs[e].
  - raw = (e == idx) ? min2 : min1.
  - out_mag = (raw > OFFSET) ? raw - OFFSET : 0.
  - out_edge = e.
  - out_last = (e == deg_eff-1).
- Index out of range: if idx >= deg_eff, every edge uses min1.
- Output registers: all outputs come from registers.
- Stall: while out_valid & !out_ready, all out_* hold stable.
- Advance: on out_valid & out_ready, if not last, e increments and the next beat is presented on the following cycle. Throughput is 1 beat/cycle.
- Last beat accepted:
  - If a new record is accepted in the same cycle, the first beat of the new record appears on the next cycle with no bubble.
  - Otherwise out_valid drops to 0 and the FSM returns to IDLE.
- Width rules:
  - min2 >= min1 is not checked; values are used as given.
  - No magnitude growth; subtraction saturates at 0, with no wrap.

Decomposition:
- Package ldpc_msg_pkg holds:
  - MAG_W, IDX_W, MAX_DEG and OFFSET defaults.
  - The FSM state encoding (IDLE, STREAM).
  - A compressed-record struct (min1, min2, idx, signs, deg), shared with the min-sum unit and the record store.
- One sub-module, cn_sign_parity: combinational masked XOR reduction of signs over deg_eff, producing P.

Test Plan:
- Base record: min1=1, min2=2, idx=1, deg=20, signs=0, out_ready=1. Expect 20 beats on consecutive cycles, first beat 1 cycle after accept:
  - Edge 1: mag 1.
  - All other edges: mag 0.
  - All signs 0.
  - out_last only on edge 19.
- Signs: signs=20'h00005 (edges 0 and 2 negative), deg=20, min1=5, min2=9, idx=3. Expect:
  - P=0; edges 0 and 2 have sign 1, the rest 0.
  - Edge 3: mag 8; all other edges: mag 4.
- Degree and index limits: deg=3, idx=7, signs=20'hFFFFF, min1=4. Expect:
  - Exactly 3 beats, all mag 3, sign 0 (P=1, each sign bit 1).
  - deg=0 accepts the record with no beats; deg=25 yields 20 beats.
- Back-pressure: toggle out_ready every cycle. Expect:
  - out_* held stable during stalls.
  - No edge skipped or duplicated.
  - New record offered on the last-beat handshake cycle is accepted there, with its edge 0 on the next cycle.
- Reset mid-record: assert rst after edge 5 of a deg=20 record. Expect:
  - Next cycle out_valid=0 with all outputs 0.
  - After rst is released, in_ready=1 and a new record streams from edge 0.
